// File: rtl/piezo_alarm_pkg.sv
// Shared battery-state encoding, default thresholds and the duty-magnitude helper
// for the piezo alarm qualifier.
package piezo_alarm_pkg;

  typedef enum logic [1:0] {
    NORM      = 2'd0,
    LOW_PEND  = 2'd1,
    LOW       = 2'd2,
    NORM_PEND = 2'd3
  } batt_st_e;

  localparam logic [11:0] DEF_BATT_THR  = 12'h800;
  localparam logic [11:0] DEF_BATT_HYST = 12'h040;
  localparam int          DEF_FILT_N    = 4;
  localparam logic [11:0] DEF_OVR_THR   = 12'd1536;
  localparam int          DEF_OVR_HOLD  = 25_000_000;

  // |duty| for a 12-bit two's-complement value; -2048 has no positive twin, so clamp to 2047.
  function automatic logic [11:0] duty_mag(input logic [11:0] duty);
    if (duty == 12'h800) return 12'd2047;
    else if (duty[11])   return (~duty) + 12'd1;
    else                 return duty;
  endfunction

endpackage

// File: rtl/piezo_hyst_filt.sv
// Battery-low hysteresis FSM with a consecutive-sample filter in each direction.
// low_nxt_o is the next-cycle alarm level; the caller registers it (1-clock strobe-to-output).
module piezo_hyst_filt
  import piezo_alarm_pkg::*;
#(
  parameter logic [11:0] BATT_THR  = DEF_BATT_THR,
  parameter logic [11:0] BATT_HYST = DEF_BATT_HYST,
  parameter int          FILT_N    = DEF_FILT_N
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [11:0] batt_i,
  input  logic        batt_vld_i,
  output logic        low_nxt_o
);

  localparam logic [12:0] EXIT_THR  = {1'b0, BATT_THR} + {1'b0, BATT_HYST};
  localparam logic [3:0]  FILT_LAST = 4'(FILT_N);

  batt_st_e   state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] cnt_inc;
  logic       below, above;

  assign below   = batt_i < BATT_THR;
  assign above   = {1'b0, batt_i} >= EXIT_THR;
  assign cnt_inc = cnt_q + 4'd1;

  // NORM/LOW hold cnt_q at 0, so their first qualifying sample shares the pending-state path.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (batt_vld_i) begin
      case (state_q)
        NORM, LOW_PEND: begin
          if (below) begin
            if (cnt_inc == FILT_LAST) begin
              state_d = LOW;
              cnt_d   = 4'd0;
            end else begin
              state_d = LOW_PEND;
              cnt_d   = cnt_inc;
            end
          end else begin
            state_d = NORM;
            cnt_d   = 4'd0;
          end
        end
        LOW, NORM_PEND: begin
          if (above) begin
            if (cnt_inc == FILT_LAST) begin
              state_d = NORM;
              cnt_d   = 4'd0;
            end else begin
              state_d = NORM_PEND;
              cnt_d   = cnt_inc;
            end
          end else begin
            state_d = LOW;
            cnt_d   = 4'd0;
          end
        end
        default: begin
          state_d = NORM;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  assign low_nxt_o = (state_d == LOW) || (state_d == NORM_PEND);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= NORM;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/piezo_alarm_qual.sv
// Qualifies battery-low, over-speed and steering-enabled alarm requests; all outputs registered,
// 1-clock strobe latency. Optional mute input under PIEZO_MUTE_EN gates en_steer and batt_low.
module piezo_alarm_qual
  import piezo_alarm_pkg::*;
#(
  parameter logic [11:0] BATT_THR  = DEF_BATT_THR,
  parameter logic [11:0] BATT_HYST = DEF_BATT_HYST,
  parameter int          FILT_N    = DEF_FILT_N,
  parameter logic [11:0] OVR_THR   = DEF_OVR_THR,
  parameter int          OVR_HOLD  = DEF_OVR_HOLD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] batt,
  input  logic        batt_vld,
  input  logic [11:0] mtr_duty,
  input  logic        duty_vld,
  input  logic        pwr_up,
`ifdef PIEZO_MUTE_EN
  input  logic        mute,
`endif
  output logic        en_steer,
  output logic        ovr_spd,
  output logic        batt_low
);

  localparam int          HW        = (OVR_HOLD > 1) ? $clog2(OVR_HOLD + 1) : 1;
  localparam logic [HW-1:0] HOLD_INIT = HW'(OVR_HOLD);

  logic          mute_w;
  logic          low_nxt;
  logic [11:0]   mag;
  logic [HW-1:0] hold_q, hold_d;
  logic          ovr_d;
  logic          ovr_spd_q, batt_low_q, en_steer_q, sync1_q;

`ifdef PIEZO_MUTE_EN
  assign mute_w = mute;
`else
  assign mute_w = 1'b0;
`endif

  piezo_hyst_filt #(
    .BATT_THR  (BATT_THR),
    .BATT_HYST (BATT_HYST),
    .FILT_N    (FILT_N)
  ) u_hyst_filt (
    .clk_i      (clk),
    .rst_i      (rst),
    .batt_i     (batt),
    .batt_vld_i (batt_vld),
    .low_nxt_o  (low_nxt)
  );

  assign mag = duty_mag(mtr_duty);

  always_comb begin
    hold_d = hold_q;
    if (duty_vld && (mag > OVR_THR)) hold_d = HOLD_INIT;
    else if (hold_q != '0)           hold_d = hold_q - HW'(1);
  end

  assign ovr_d = hold_d != '0;

  // en_steer_q doubles as the second synchronizer stage, gated by the next over-speed level.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q     <= '0;
      ovr_spd_q  <= 1'b0;
      batt_low_q <= 1'b0;
      sync1_q    <= 1'b0;
      en_steer_q <= 1'b0;
    end else begin
      hold_q     <= hold_d;
      ovr_spd_q  <= ovr_d;
      batt_low_q <= low_nxt & ~mute_w;
      sync1_q    <= pwr_up;
      en_steer_q <= sync1_q & ~ovr_d & ~mute_w;
    end
  end

  assign en_steer = en_steer_q;
  assign ovr_spd  = ovr_spd_q;
  assign batt_low = batt_low_q;

endmodule

// File: tb/tb_piezo_alarm_qual.sv
// Directed bench for piezo_alarm_qual with a cycle-level behavioural model and literal spot checks.
module tb_piezo_alarm_qual;

  localparam int THR     = 'h800;
  localparam int EXIT    = 'h840;
  localparam int FILT    = 4;
  localparam int OTHR    = 1536;
  localparam int HOLD    = 16;
  localparam int BIG     = 1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] batt = '0;
  logic        batt_vld = 1'b0;
  logic [11:0] mtr_duty = '0;
  logic        duty_vld = 1'b0;
  logic        pwr_up = 1'b0;
  logic        en_steer, ovr_spd, batt_low;

  int checks = 0;
  int failures = 0;
  bit chk_on = 1'b0;

  // model state
  bit m_low = 1'b0;
  int m_run = 0;
  int m_since = BIG;
  bit m_p1 = 1'b0, m_p2 = 1'b0;

  piezo_alarm_qual #(
    .FILT_N   (FILT),
    .OVR_HOLD (HOLD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .batt     (batt),
    .batt_vld (batt_vld),
    .mtr_duty (mtr_duty),
    .duty_vld (duty_vld),
    .pwr_up   (pwr_up),
    .en_steer (en_steer),
    .ovr_spd  (ovr_spd),
    .batt_low (batt_low)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Model: what each output must be after this edge, from the rules in plain terms.
  always @(posedge clk) begin
    int bi, dv, mg;
    bit qual;
    if (rst) begin
      m_low = 1'b0; m_run = 0; m_since = BIG; m_p1 = 1'b0; m_p2 = 1'b0;
    end else begin
      if (batt_vld) begin
        bi = int'(batt);
        qual = m_low ? (bi >= EXIT) : (bi < THR);
        if (qual) begin
          m_run++;
          if (m_run == FILT) begin
            m_low = !m_low;
            m_run = 0;
          end
        end else begin
          m_run = 0;
        end
      end
      dv = int'($signed(mtr_duty));
      mg = (dv < 0) ? -dv : dv;
      if (mg > 2047) mg = 2047;
      if (duty_vld && mg > OTHR) m_since = 0;
      else if (m_since < BIG)    m_since++;
      m_p2 = m_p1;
      m_p1 = pwr_up;
    end
  end

  always @(negedge clk) begin
    bit exp_ovr;
    if (chk_on) begin
      exp_ovr = m_since < HOLD;
      chk("model_batt_low", batt_low, m_low);
      chk("model_ovr_spd", ovr_spd, exp_ovr);
      chk("model_en_steer", en_steer, m_p2 && !exp_ovr);
    end
  end

  task automatic cyc(input logic [11:0] b, input logic bv, input logic [11:0] d, input logic dv);
    batt = b; batt_vld = bv; mtr_duty = d; duty_vld = dv;
    @(posedge clk); #1;
    batt_vld = 1'b0; duty_vld = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(12'h000, 1'b0, 12'h000, 1'b0);
  endtask

  task automatic bsamp(input logic [11:0] b, input int n);
    for (int i = 0; i < n; i++) cyc(b, 1'b1, 12'h000, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_on = 1'b1;
    chk("reset_batt_low", batt_low, 1'b0);
    chk("reset_ovr_spd", ovr_spd, 1'b0);
    chk("reset_en_steer", en_steer, 1'b0);
    rst = 1'b0;

    // battery entry filter: three lows then a threshold-equal sample
    bsamp(12'h7FF, 3);
    bsamp(12'h800, 1);
    chk("entry_broken_by_800", batt_low, 1'b0);
    bsamp(12'h7FF, 3);
    chk("entry_after_3", batt_low, 1'b0);
    bsamp(12'h7FF, 1);
    chk("entry_after_4", batt_low, 1'b1);

    // exit filter: just below exit threshold, then at it
    bsamp(12'h83F, 4);
    chk("exit_83f_stays", batt_low, 1'b1);
    bsamp(12'h840, 3);
    chk("exit_after_3", batt_low, 1'b1);
    bsamp(12'h840, 1);
    chk("exit_after_4", batt_low, 1'b0);

    // idle cycles between strobes do not disturb the count
    bsamp(12'h100, 2);
    idle(3);
    bsamp(12'h100, 1);
    chk("gap_after_3", batt_low, 1'b0);
    bsamp(12'h100, 1);
    chk("gap_after_4", batt_low, 1'b1);
    bsamp(12'hFFF, 4);
    chk("exit_fff", batt_low, 1'b0);

    // over-speed hold timing
    cyc(12'h000, 1'b0, 12'h601, 1'b1);
    chk("ovr_1537_rise", ovr_spd, 1'b1);
    idle(15);
    chk("ovr_hold_15", ovr_spd, 1'b1);
    idle(1);
    chk("ovr_hold_16", ovr_spd, 1'b0);
    cyc(12'h000, 1'b0, 12'h600, 1'b1);
    chk("ovr_1536_none", ovr_spd, 1'b0);
    cyc(12'h000, 1'b0, 12'hA00, 1'b1);
    chk("ovr_m1536_none", ovr_spd, 1'b0);
    cyc(12'h000, 1'b0, 12'h9FF, 1'b1);
    chk("ovr_m1537_rise", ovr_spd, 1'b1);
    idle(16);

    // -2048 then a reload when three hold cycles remain
    cyc(12'h000, 1'b0, 12'h800, 1'b1);
    chk("ovr_m2048_rise", ovr_spd, 1'b1);
    idle(13);
    cyc(12'h000, 1'b0, 12'h800, 1'b1);
    idle(15);
    chk("ovr_reload_15", ovr_spd, 1'b1);
    idle(1);
    chk("ovr_reload_16", ovr_spd, 1'b0);

    // steering enable sync and over-speed gating
    pwr_up = 1'b1;
    idle(1);
    chk("en_steer_1clk", en_steer, 1'b0);
    idle(1);
    chk("en_steer_2clk", en_steer, 1'b1);
    cyc(12'h000, 1'b0, 12'h7FF, 1'b1);
    chk("en_gate_ovr", ovr_spd, 1'b1);
    chk("en_gate_en", en_steer, 1'b0);
    idle(16);
    chk("en_restored", en_steer, 1'b1);

    // reset mid-filter and mid-hold, last low sample coincident with duty strobe
    bsamp(12'h7FF, 2);
    cyc(12'h7FF, 1'b1, 12'h601, 1'b1);
    chk("both_strobes_ovr", ovr_spd, 1'b1);
    chk("both_strobes_low", batt_low, 1'b0);
    idle(2);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("rst_batt_low", batt_low, 1'b0);
    chk("rst_ovr_spd", ovr_spd, 1'b0);
    chk("rst_en_steer", en_steer, 1'b0);
    bsamp(12'h7FF, 1);
    chk("post_rst_one_low", batt_low, 1'b0);
    idle(3);
    chk("post_rst_en", en_steer, 1'b1);

    @(negedge clk);
    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
